alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 8-bit registered ALU between two requesters, e.g. the instruction datapath (port 0) and the address/stack helper (port 1).
- Arbitrates round-robin and drives the ALU operand and op inputs from registers.
- Waits out the ALU's one-cycle registered latency, captures the result and flags, and returns them with a done pulse to the requester that was granted.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- OP_W, 3, op code width.
- NUM_OPS, 4, legal op codes are 0..NUM_OPS-1 (ADD, AND, OR, XOR); codes at or above NUM_OPS are illegal.

Ports:
- i_clk  in  1  clock, all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req0  in  1  requester 0 request; held until o_ack0.
- i_l0  in  DATA_W  requester 0 left operand.
- i_r0  in  DATA_W  requester 0 right operand.
- i_op0  in  OP_W  requester 0 op code.
- o_ack0  out  1  requester 0 accepted this cycle (combinational).
- o_done0  out  1  requester 0 result valid, 1-cycle pulse.
- i_req1, i_l1, i_r1, i_op1, o_ack1, o_done1: same as port 0, for requester 1.
- o_res  out  DATA_W  captured result, shared by both requesters.
- o_flags  out  4  captured ALU flags, passed through verbatim.
- o_err  out  1  the completed request had an illegal op.
- o_alu_l  out  DATA_W  to ALU left operand (registered).
- o_alu_r  out  DATA_W  to ALU right operand (registered).
- o_alu_op  out  OP_W  to ALU op (registered).
- i_alu  in  DATA_W  ALU result.
- i_alu_flags  in  4  ALU flags.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values:
  - state IDLE; RR pointer = 1, so port 0 wins the first tie.
  - o_done0/1 = 0, o_err = 0, o_res = 0, o_flags = 0.
  - o_alu_l/r = 0; o_alu_op = 1 (AND, which does not disturb ALU carry).
- State IDLE:
  - Grant = the only requester asserting, or on a tie the one not last granted.
  - o_ackN = (state==IDLE) && grantN && i_reqN.
  - On ack, the edge loads o_alu_l/r/op from the granted port, stores grant id, records illegal = (op >= NUM_OPS), updates RR pointer to the grant, and goes to ISSUE.
  - For an illegal op, o_alu_op is loaded with 1 (AND) so the ALU carry is preserved.
  - No request: stay in IDLE and keep o_alu_* unchanged.
- State ISSUE:
  - ALU inputs are stable; the ALU registers its result at the end of this cycle.
  - Next state CAPT.
- State CAPT:
  - i_alu and i_alu_flags are valid.
  - The edge loads o_res/o_flags from i_alu/i_alu_flags, or 0/0 if illegal.
  - The same edge sets o_err = illegal, pulses o_doneN for the stored grant id, and goes to IDLE.
- Done and result hold:
  - o_doneN is high exactly one cycle, the first IDLE cycle after CAPT.
  - o_res/o_flags/o_err hold until the next CAPT.
- Timing:
  - Latency: ack in cycle T, done in cycle T+3, result valid with done.
  - Throughput: a new ack is allowed in the same cycle as the done, so one op per 3 cycles.
  - Under continuous requests from both ports, grants strictly alternate.
- Requester rules:
  - A requester must hold i_reqN and its operands stable until o_ackN.
  - Operands may change after ack; the arbiter has already latched them.
  - Requests seen in ISSUE or CAPT are not acked; they wait for IDLE.
- Carry: ADD updates ALU carry. Logic ops leave carry as last set, and o_flags[1] reflects that. The arbiter does not modify flags.
- Reset mid-operation (ISSUE or CAPT): return to IDLE with all reset values; no done is issued for the aborted request; the requester must re-request.
- i_reset has priority over every state transition and over any ack in the same cycle. o_ack0/1 = 0 while i_reset is high.

Test Plan:
- Single port 0: ADD 0x12+0x34 -> o_ack0 at T; o_done0 at T+3; o_res=0x46; o_flags equals the ALU flags (Z=0, C=0); o_done1 never high.
- Carry and zero: port 1 ADD 0x80+0x80 -> o_res=0x00, o_flags=4'b0111 as delivered by the ALU; then port 1 XOR 0xAA^0xAA -> o_res=0x00, flags[1] still 1.
- Simultaneous requests out of reset, both held high for 4 ops:
  - acks go to port 0, 1, 0, 1;
  - each done arrives 3 cycles after its ack, on the matching port;
  - results are correct for operands 0x0F&0xF3 (0x03) and 0x50|0x05 (0x55).
- Illegal op 5 on port 0 -> acked; o_alu_op driven 1; done at T+3 with o_err=1, o_res=0, o_flags=0. The next legal op clears o_err.
- Reset asserted in ISSUE -> next cycle IDLE, no o_done0/o_done1 pulse, outputs at reset values. A held port 1 request is then acked, since port 0 wins only ties.
- Late request: port 1 raises i_req1 during ISSUE of a port 0 op -> no ack until the IDLE cycle carrying o_done0, where o_ack1 is asserted in that same cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one registered 8-bit ALU
// between two requesters, returning result, flags and a done pulse.
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int NUM_OPS = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic [DATA_W-1:0] i_l0,
  input  logic [DATA_W-1:0] i_r0,
  input  logic [OP_W-1:0]   i_op0,
  output logic              o_ack0,
  output logic              o_done0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_l1,
  input  logic [DATA_W-1:0] i_r1,
  input  logic [OP_W-1:0]   i_op1,
  output logic              o_ack1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_res,
  output logic [3:0]        o_flags,
  output logic              o_err,
  output logic [DATA_W-1:0] o_alu_l,
  output logic [DATA_W-1:0] o_alu_r,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [3:0]        i_alu_flags
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT
  } state_t;

  localparam logic [OP_W:0]   OP_LIM = (OP_W+1)'(NUM_OPS);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(1);

  state_t state;
  state_t state_nx;

  logic              rr_last;
  logic              gid;
  logic              illegal;
  logic              grant;
  logic              take;
  logic              bad;
  logic [OP_W-1:0]   op_sel;
  logic [DATA_W-1:0] l_sel;
  logic [DATA_W-1:0] r_sel;

  // Pick the lone requester, or on a tie the one not served last.
  always_comb begin
    grant  = i_req1 && (!i_req0 || !rr_last);
    take   = (state == IDLE) && !i_reset && (i_req0 || i_req1);
    o_ack0 = take && !grant;
    o_ack1 = take && grant;
    op_sel = grant ? i_op1 : i_op0;
    l_sel  = grant ? i_l1 : i_l0;
    r_sel  = grant ? i_r1 : i_r0;
    bad    = {1'b0, op_sel} >= OP_LIM;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state: one issue cycle, one capture cycle, then back to idle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = ISSUE;
      ISSUE:   state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand launch on ack, result capture and done pulse after CAPT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_last  <= 1'b1;
      gid      <= 1'b0;
      illegal  <= 1'b0;
      o_done0  <= 1'b0;
      o_done1  <= 1'b0;
      o_err    <= 1'b0;
      o_res    <= '0;
      o_flags  <= '0;
      o_alu_l  <= '0;
      o_alu_r  <= '0;
      o_alu_op <= OP_AND;
    end else begin
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      if (take) begin
        o_alu_l  <= l_sel;
        o_alu_r  <= r_sel;
        o_alu_op <= bad ? OP_AND : op_sel;
        illegal  <= bad;
        gid      <= grant;
        rr_last  <= grant;
      end
      if (state == CAPT) begin
        o_res   <= illegal ? '0 : i_alu;
        o_flags <= illegal ? 4'b0000 : i_alu_flags;
        o_err   <= illegal;
        o_done0 <= !gid;
        o_done1 <= gid;
      end
    end
  end

endmodule
